// File: rtl/lib_stream_realign_if.sv
// Handshake bundle for lib_stream_realign: unaligned input beats in,
// packed zero-based output beats out.
interface lib_stream_realign_if #(
    parameter int DATA_BYTES = 16
);
    localparam int OW = $clog2(DATA_BYTES);

    logic                    in_val;
    logic                    in_rdy;
    logic [DATA_BYTES*8-1:0] in_data;
    logic                    in_first;
    logic [OW-1:0]           in_offset;
    logic                    in_last;
    logic [OW:0]             in_tail;
    logic                    out_val;
    logic                    out_rdy;
    logic [DATA_BYTES*8-1:0] out_data;
    logic [DATA_BYTES-1:0]   out_keep;
    logic                    out_last;

    modport slave (
        input  in_val, in_data, in_first, in_offset, in_last, in_tail, out_rdy,
        output in_rdy, out_val, out_data, out_keep, out_last
    );

    modport master (
        output in_val, in_data, in_first, in_offset, in_last, in_tail, out_rdy,
        input  in_rdy, out_val, out_data, out_keep, out_last
    );
endinterface

// File: rtl/lib_stream_realign.sv
// Stream realigner: strips leading/trailing invalid bytes of a transfer and
// repacks the remaining bytes into zero-based full beats plus one final partial beat.
module lib_stream_realign #(
    parameter int DATA_BYTES = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    lib_stream_realign_if.slave   bus,
    output logic                  err_proto
);
    localparam int W  = DATA_BYTES * 8;
    localparam int OW = $clog2(DATA_BYTES);
    localparam int CW = OW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DATA_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                state_r;
    logic [OW-1:0]         hcnt_r;
    logic [W-1:0]          res_r;
    logic [W-1:0]          out_data_r;
    logic [DATA_BYTES-1:0] out_keep_r;
    logic                  out_val_r;
    logic                  out_last_r;
    logic                  err_r;

    logic                  out_free_s;
    logic                  in_rdy_s;
    logic                  acc_s;
    logic                  restart_s;
    logic                  proto_err_s;
    logic [OW-1:0]         start_s;
    logic [OW-1:0]         hbase_s;
    logic [CW-1:0]         end_s;
    logic [CW-1:0]         nvalid_s;
    logic [CW-1:0]         total_s;
    logic [CW-1:0]         rem_s;
    logic                  full_s;
    logic [DATA_BYTES-1:0] bmask_s;
    logic [W-1:0]          in_masked_s;
    logic [W-1:0]          res_masked_s;
    logic [2*W-1:0]        cat_s;

    function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [CW-1:0] n);
        logic [DATA_BYTES-1:0] m;
        for (int i = 0; i < DATA_BYTES; i++) begin
            m[i] = (CW'(i) < n);
        end
        return m;
    endfunction

    // Handshake, valid-byte window and concatenation of new bytes behind the residue
    always_comb begin
        bmask_s      = {DATA_BYTES{1'b0}};
        in_masked_s  = {W{1'b0}};
        out_free_s   = !out_val_r || bus.out_rdy;
        in_rdy_s     = out_free_s && (state_r != FLUSH);
        acc_s        = bus.in_val && in_rdy_s;
        // A beat seen with no transfer open, or a new first beat, starts from an empty residue
        restart_s    = bus.in_first || (state_r == IDLE);
        proto_err_s  = (bus.in_first && (state_r == STREAM)) ||
                       (!bus.in_first && (state_r == IDLE));
        start_s      = bus.in_first ? bus.in_offset : {OW{1'b0}};
        end_s        = bus.in_last ? bus.in_tail : FULL_C;
        hbase_s      = restart_s ? {OW{1'b0}} : hcnt_r;
        res_masked_s = restart_s ? {W{1'b0}} : res_r;
        for (int i = 0; i < DATA_BYTES; i++) begin
            bmask_s[i] = (CW'(i) >= {1'b0, start_s}) && (CW'(i) < end_s);
            in_masked_s[8*i +: 8] = bmask_s[i] ? bus.in_data[8*i +: 8] : 8'h00;
        end
        nvalid_s = end_s - {1'b0, start_s};
        total_s  = {1'b0, hbase_s} + nvalid_s;
        full_s   = (total_s >= FULL_C);
        rem_s    = total_s - FULL_C;
        cat_s    = (({{W{1'b0}}, in_masked_s} >> {start_s, 3'b000}) << {hbase_s, 3'b000}) |
                   {{W{1'b0}}, res_masked_s};
    end

    // Transfer state machine with the single-stage output register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= IDLE;
            hcnt_r     <= {OW{1'b0}};
            res_r      <= {W{1'b0}};
            out_data_r <= {W{1'b0}};
            out_keep_r <= {DATA_BYTES{1'b0}};
            out_val_r  <= 1'b0;
            out_last_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                FLUSH: begin
                    if (out_free_s) begin
                        out_val_r  <= 1'b1;
                        out_data_r <= res_r;
                        out_keep_r <= keep_mask({1'b0, hcnt_r});
                        out_last_r <= 1'b1;
                        hcnt_r     <= {OW{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= FLUSH;
                    end
                end
                IDLE, STREAM: begin
                    if (acc_s) begin
                        if (proto_err_s) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r <= err_r;
                        end
                        if (full_s) begin
                            out_val_r  <= 1'b1;
                            out_data_r <= cat_s[W-1:0];
                            out_keep_r <= {DATA_BYTES{1'b1}};
                            res_r      <= cat_s[2*W-1:W];
                            hcnt_r     <= rem_s[OW-1:0];
                            if (bus.in_last && (rem_s == {CW{1'b0}})) begin
                                out_last_r <= 1'b1;
                                state_r    <= IDLE;
                            end else if (bus.in_last) begin
                                out_last_r <= 1'b0;
                                state_r    <= FLUSH;
                            end else begin
                                out_last_r <= 1'b0;
                                state_r    <= STREAM;
                            end
                        end else if (bus.in_last) begin
                            out_val_r  <= 1'b1;
                            out_data_r <= cat_s[W-1:0];
                            out_keep_r <= keep_mask(total_s);
                            out_last_r <= 1'b1;
                            hcnt_r     <= {OW{1'b0}};
                            state_r    <= IDLE;
                        end else begin
                            // Too few bytes for a beat yet: accumulate silently
                            out_val_r  <= 1'b0;
                            res_r      <= cat_s[W-1:0];
                            hcnt_r     <= total_s[OW-1:0];
                            state_r    <= STREAM;
                        end
                    end else if (out_free_s) begin
                        out_val_r <= 1'b0;
                    end else begin
                        out_val_r <= out_val_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy_s;
    assign bus.out_val  = out_val_r;
    assign bus.out_data = out_data_r;
    assign bus.out_keep = out_keep_r;
    assign bus.out_last = out_last_r;
    assign err_proto    = err_r;

endmodule

// File: doc/lib_stream_realign.md
LIB_STREAM_REALIGN -- requirements
Module: lib_stream_realign

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 16, giving the beat width in bytes; legal values are powers of 2 from 4 to 128.
REQ-002 The block SHALL have port CLK, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 The block SHALL have port RSTN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_val, input, 1 bit: the input beat is valid.
REQ-005 The block SHALL have port in_rdy, output, 1 bit: the block accepts the input beat.
REQ-006 The block SHALL have port in_data, input, DATA_BYTES*8 bits: input beat data, byte i at bits [8i+7:8i].
REQ-007 The block SHALL have port in_first, input, 1 bit: first beat of a transfer.
REQ-008 The block SHALL have port in_offset, input, clog2(DATA_BYTES) bits: on a first beat, the index of the first valid byte; ignored on other beats.
REQ-009 The block SHALL have port in_last, input, 1 bit: last beat of a transfer.
REQ-010 The block SHALL have port in_tail, input, clog2(DATA_BYTES)+1 bits: on a last beat, the valid byte end index (exclusive), range 1..DATA_BYTES; ignored on other beats.
REQ-011 The block SHALL have port out_val, output, 1 bit: the output beat is valid.
REQ-012 The block SHALL have port out_rdy, input, 1 bit: the downstream stage accepts the output beat.
REQ-013 The block SHALL have port out_data, output, DATA_BYTES*8 bits: packed, zero-based output data.
REQ-014 The block SHALL have port out_keep, output, DATA_BYTES bits: byte-valid mask, contiguous from bit 0.
REQ-015 The block SHALL have port out_last, output, 1 bit: final output beat of a transfer.
REQ-016 The block SHALL have port err_proto, output, 1 bit: sticky protocol-error flag.

Function
REQ-017 An input handshake SHALL occur when in_val and in_rdy are both high in the same cycle; an output handshake SHALL occur when out_val and out_rdy are both high.
REQ-018 Valid bytes of an accepted beat SHALL be: [in_offset, DATA_BYTES) if first only; [0, in_tail) if last only; [in_offset, in_tail) if first and last; all bytes otherwise. in_tail SHALL exceed in_offset when first and last coincide; otherwise the result is undefined.
REQ-019 The block SHALL keep a residue register of up to DATA_BYTES-1 bytes plus a count hcnt, and concatenate valid input bytes after the residue in stream order.
REQ-020 On an accepted beat with v valid bytes and total = hcnt+v >= DATA_BYTES, the block SHALL load a full output beat (the residue bytes, then the first DATA_BYTES-hcnt new bytes, keep all ones) and set hcnt = total-DATA_BYTES with the remaining bytes.
REQ-021 On an accepted non-last beat with total < DATA_BYTES, the block SHALL emit no output and set hcnt = total.
REQ-022 On an accepted last beat with total < DATA_BYTES, the block SHALL load one output beat with total bytes, keep = (1<<total)-1, out_last=1, and clear hcnt to 0.
REQ-023 On an accepted last beat with total >= DATA_BYTES, the block SHALL set out_last=1 on that full beat if the new hcnt is 0; otherwise it SHALL clear out_last and enter FLUSH.
REQ-024 The states SHALL be IDLE (no transfer open), STREAM (transfer open) and FLUSH (residue pending); transitions are: IDLE->STREAM on first-not-last; STREAM->IDLE on a last without residue; STREAM/IDLE->FLUSH per REQ-023; FLUSH->IDLE when the flush beat loads.
REQ-025 In FLUSH, the block SHALL load the residue as an output beat (keep = (1<<hcnt)-1, out_last=1) as soon as the output register is free, and clear hcnt.
REQ-026 in_rdy SHALL equal (!out_val | out_rdy) & (state != FLUSH), combinationally.
REQ-027 The output register SHALL be a single stage: load-to-out_val latency is 1 cycle, and full throughput (1 beat/cycle) is sustained when out_rdy stays high.
REQ-028 While out_val=1 and out_rdy=0, out_data, out_keep and out_last SHALL hold stable.
REQ-029 Output bytes with a keep bit of 0 SHALL be driven to 0.
REQ-030 If in_first is accepted in STREAM, the block SHALL set err_proto, discard the residue, and start the new transfer.
REQ-031 If a non-first beat is accepted in IDLE, the block SHALL set err_proto and treat the beat as first with offset 0.
REQ-032 err_proto SHALL clear only on reset.

Reset
REQ-033 While RSTN=0, the block SHALL drive out_val=0, out_last=0, out_keep=0, err_proto=0, hcnt=0, state=IDLE, and in_rdy=1; out_data is don't-care.
REQ-034 Assertion of RSTN SHALL abort any transfer in progress, including FLUSH, with no further output beats.

Verification (DATA_BYTES=16)
REQ-035 The bench SHALL cover a single beat with first=last=1, offset=4, tail=12, in_data bytes 0..15 = 0x00..0x0F: one output beat follows one cycle later with bytes 0x04..0x0B, keep=0x00FF, last=1.
REQ-036 The bench SHALL cover three beats with offset=0 and tail=16: three passthrough beats on consecutive cycles, keep=0xFFFF, last on the third only.
REQ-037 The bench SHALL cover two beats with offset=5 and tail=16: out beat 1 is full (input bytes 5..15 of beat 0, then bytes 0..4 of beat 1); out beat 2 has keep=0x07FF and last=1; in_rdy=0 during the FLUSH cycle.
REQ-038 The bench SHALL cover out_rdy held at 0 for 10 cycles with out_val=1: in_rdy stays 0, outputs stay stable, and no beat is lost or duplicated after release.
REQ-039 The bench SHALL cover in_first asserted mid-transfer: err_proto goes to 1 and stays high, and the new transfer outputs correctly with no old residue.
REQ-040 The bench SHALL cover RSTN pulsed low during FLUSH: outputs immediately take the values of REQ-033, and the next transfer is correct.
